cnn_accel_top: RTL and testbench

// - Sequential CNN/MLP inference engine behind AXI-fed memories. The host loads activations (LDM), layer contexts (CRAM), weights (WRAM) and biases (BRAM), then pulses start_in.
// - The engine runs context-described dense layers on one MAC and reports the argmax class label with complete_out.

---
 rtl/cnn_accel_top.sv | 226 ++++++++++++++++++++++
 tb/tb_cnn_accel_top.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_accel_top.sv
// Sequential dense-layer inference engine: ping/pong LDM, context/weight/bias RAMs, one MAC, argmax label.
// Optional CNN_SAT_EN: saturating writeback (default build wraps to DATA_WIDTH bits).
module cnn_accel_top #(
    parameter int DATA_WIDTH     = 16,
    parameter int FRAC           = 8,
    parameter int PE_NUM         = 20,
    parameter int PE_NUM_BITS    = 5,
    parameter int LDM_NUM_BITS   = 1,
    parameter int LDM_ADDR_BITS  = 4,
    parameter int CRAM_ADDR_BITS = 6,
    parameter int CTX_BITS       = 32,
    parameter int WRAM_ADDR_BITS = 14,
    parameter int BRAM_ADDR_BITS = 8,
    parameter int LABEL          = 9
) (
    input  logic                                            CLK,
    input  logic                                            RST,
    input  logic [PE_NUM_BITS+LDM_NUM_BITS+LDM_ADDR_BITS-1:0] AXI_LDM_addra_in,
    input  logic [DATA_WIDTH-1:0]                           AXI_LDM_dina_in,
    input  logic                                            AXI_LDM_ena_in,
    input  logic                                            AXI_LDM_wea_in,
    input  logic [CRAM_ADDR_BITS-1:0]                       AXI_CRAM_addra_in,
    input  logic [CTX_BITS-1:0]                             AXI_CRAM_dina_in,
    input  logic                                            AXI_CRAM_ena_in,
    input  logic                                            AXI_CRAM_wea_in,
    input  logic [WRAM_ADDR_BITS-1:0]                       AXI_WRAM_addra_in,
    input  logic [DATA_WIDTH-1:0]                           AXI_WRAM_dina_in,
    input  logic                                            AXI_WRAM_ena_in,
    input  logic                                            AXI_WRAM_wea_in,
    input  logic [BRAM_ADDR_BITS-1:0]                       AXI_BRAM_addra_in,
    input  logic [DATA_WIDTH-1:0]                           AXI_BRAM_dina_in,
    input  logic                                            AXI_BRAM_ena_in,
    input  logic                                            AXI_BRAM_wea_in,
    input  logic                                            start_in,
    output logic [LABEL-1:0]                                AXI_LDM_douta_out,
    output logic                                            complete_out
);
    localparam int BANK_WORDS = PE_NUM * (2 ** LDM_ADDR_BITS);
    localparam int LDM_WORDS  = BANK_WORDS * (2 ** LDM_NUM_BITS);
    localparam int IDX_W      = $clog2(LDM_WORDS);
    localparam int ACC_W      = 2 * DATA_WIDTH + 8;
    localparam int CF_W       = 22;  // {last, relu, src, dst, in_len[8:0], out_len[8:0]}

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_BIAS, S_MAC, S_WRITE, S_DONE} state_t;

    logic [DATA_WIDTH-1:0] ldm_q  [LDM_WORDS];
    logic [CF_W-1:0]       cram_q [2**CRAM_ADDR_BITS];
    logic [DATA_WIDTH-1:0] wram_q [2**WRAM_ADDR_BITS];
    logic [DATA_WIDTH-1:0] bram_q [2**BRAM_ADDR_BITS];

    state_t                     state_q, state_d;
    logic [CRAM_ADDR_BITS-1:0]  ctx_ptr_q, ctx_ptr_d;
    logic [WRAM_ADDR_BITS-1:0]  wptr_q, wptr_d;
    logic [BRAM_ADDR_BITS-1:0]  bptr_q, bptr_d;
    logic [CF_W-1:0]            ctx_q, ctx_d;
    logic [8:0]                 o_q, o_d, i_q, i_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] best_q, best_d;
    logic [LABEL-1:0]           arg_q, arg_d, label_q, label_d;
    logic                       mac_vld_q, mac_vld_d;
    logic [CF_W-1:0]            cram_rd_q;
    logic [DATA_WIDTH-1:0]      bram_rd_q, ldm_rd_q, w_rd_q;
    logic                       eng_we, cram_unused;

    logic [PE_NUM_BITS-1:0]   axi_pe;
    logic [LDM_NUM_BITS-1:0]  axi_bank;
    logic [LDM_ADDR_BITS-1:0] axi_word;
    logic [IDX_W-1:0]         axi_idx, rd_idx, wr_idx;
    logic                     axi_ldm_we, rd_ok, wr_ok, last_eff;

    logic [8:0] in_len, out_len;
    assign in_len   = ctx_q[17:9];
    assign out_len  = ctx_q[8:0];
    assign last_eff = ctx_q[21] || (ctx_ptr_q == '1);
    assign cram_unused = ^AXI_CRAM_dina_in[27:18];

    assign {axi_pe, axi_bank, axi_word} = AXI_LDM_addra_in;
    assign axi_idx    = IDX_W'(32'(axi_bank) * BANK_WORDS + 32'(axi_word) * PE_NUM + 32'(axi_pe));
    assign axi_ldm_we = AXI_LDM_ena_in && AXI_LDM_wea_in && (32'(axi_pe) < PE_NUM) &&
                        (state_q == S_IDLE || state_q == S_DONE);
    assign rd_idx = IDX_W'(32'(ctx_q[19]) * BANK_WORDS + 32'(i_q));
    assign rd_ok  = 32'(i_q) < BANK_WORDS;
    assign wr_idx = IDX_W'(32'(ctx_q[18]) * BANK_WORDS + 32'(o_q));
    assign wr_ok  = 32'(o_q) < BANK_WORDS;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        y_full;
    logic signed [DATA_WIDTH-1:0]   y;
    assign prod = $signed(ldm_rd_q) * $signed(w_rd_q);

    always_comb begin
        y_full = acc_q >>> FRAC;
`ifdef CNN_SAT_EN
        if (y_full > ACC_W'((64'sd1 <<< (DATA_WIDTH-1)) - 64'sd1))
            y = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (y_full < ACC_W'(-(64'sd1 <<< (DATA_WIDTH-1))))
            y = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
            y = DATA_WIDTH'(y_full);
`else
        y = DATA_WIDTH'(y_full);
`endif
        if (ctx_q[20] && y < 0) y = '0;
    end

    // Per output: BIAS 1 + MAC in_len+1 (one-cycle read latency drain) + WRITE 1; no extra fill.
    always_comb begin
        state_d   = state_q;
        ctx_ptr_d = ctx_ptr_q;
        wptr_d    = wptr_q;
        bptr_d    = bptr_q;
        ctx_d     = ctx_q;
        o_d       = o_q;
        i_d       = i_q;
        acc_d     = acc_q;
        best_d    = best_q;
        arg_d     = arg_q;
        label_d   = label_q;
        eng_we    = 1'b0;
        mac_vld_d = (state_q == S_MAC) && (i_q != in_len);
        case (state_q)
            S_IDLE, S_DONE: if (start_in) begin
                state_d   = S_FETCH;
                ctx_ptr_d = '0;
                wptr_d    = '0;
                bptr_d    = '0;
                best_d    = '0;
                arg_d     = '0;
            end
            S_FETCH: begin
                ctx_d = cram_rd_q;
                o_d   = '0;
                i_d   = '0;
                if (cram_rd_q[8:0] == '0) begin
                    if (cram_rd_q[21] || ctx_ptr_q == '1) begin
                        state_d = S_DONE;
                        label_d = arg_q;
                    end else begin
                        ctx_ptr_d = ctx_ptr_q + 1'b1;
                    end
                end else begin
                    state_d = S_BIAS;
                end
            end
            S_BIAS: begin
                acc_d   = ACC_W'($signed(bram_rd_q)) <<< FRAC;
                i_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (mac_vld_q) acc_d = acc_q + ACC_W'(prod);
                if (i_q == in_len) state_d = S_WRITE;
                else               i_d = i_q + 1'b1;
            end
            S_WRITE: begin
                eng_we = 1'b1;
                wptr_d = wptr_q + WRAM_ADDR_BITS'(in_len);
                bptr_d = bptr_q + 1'b1;
                o_d    = o_q + 1'b1;
                if (last_eff && (o_q == '0 || y > best_q)) begin
                    best_d = y;
                    arg_d  = LABEL'(o_q);
                end
                if (o_q + 9'd1 == out_len) begin
                    if (last_eff) begin
                        state_d = S_DONE;
                        label_d = arg_d;
                    end else begin
                        ctx_ptr_d = ctx_ptr_q + 1'b1;
                        state_d   = S_FETCH;
                    end
                end else begin
                    state_d = S_BIAS;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            ctx_ptr_q <= '0;
            wptr_q    <= '0;
            bptr_q    <= '0;
            ctx_q     <= '0;
            o_q       <= '0;
            i_q       <= '0;
            acc_q     <= '0;
            best_q    <= '0;
            arg_q     <= '0;
            label_q   <= '0;
            mac_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctx_ptr_q <= ctx_ptr_d;
            wptr_q    <= wptr_d;
            bptr_q    <= bptr_d;
            ctx_q     <= ctx_d;
            o_q       <= o_d;
            i_q       <= i_d;
            acc_q     <= acc_d;
            best_q    <= best_d;
            arg_q     <= arg_d;
            label_q   <= label_d;
            mac_vld_q <= mac_vld_d;
        end
    end

    // Memories survive reset; CRAM/BRAM read addresses follow next-state pointers so data is ready on entry.
    always_ff @(posedge CLK) begin
        if (eng_we && wr_ok)  ldm_q[wr_idx]  <= y;
        else if (axi_ldm_we)  ldm_q[axi_idx] <= AXI_LDM_dina_in;
        if (AXI_CRAM_ena_in && AXI_CRAM_wea_in)
            cram_q[AXI_CRAM_addra_in] <= {AXI_CRAM_dina_in[31:28], AXI_CRAM_dina_in[17:0]};
        if (AXI_WRAM_ena_in && AXI_WRAM_wea_in) wram_q[AXI_WRAM_addra_in] <= AXI_WRAM_dina_in;
        if (AXI_BRAM_ena_in && AXI_BRAM_wea_in) bram_q[AXI_BRAM_addra_in] <= AXI_BRAM_dina_in;
        cram_rd_q <= cram_q[ctx_ptr_d];
        bram_rd_q <= bram_q[bptr_d];
        ldm_rd_q  <= rd_ok ? ldm_q[rd_idx] : '0;
        w_rd_q    <= wram_q[wptr_q + WRAM_ADDR_BITS'(i_q)];
    end

    assign AXI_LDM_douta_out = label_q;
    assign complete_out      = (state_q == S_DONE);
endmodule

// File: tb/tb_cnn_accel_top.sv
// Bench for cnn_accel_top: directed and random layer stacks checked against an arithmetic layer model.
module tb_cnn_accel_top;
    localparam int BANK = 320;

    logic        CLK = 1'b0, RST = 1'b0;
    logic [9:0]  ldm_addr;  logic [15:0] ldm_din;  logic ldm_en, ldm_we;
    logic [5:0]  cram_addr; logic [31:0] cram_din; logic cram_en, cram_we;
    logic [13:0] wram_addr; logic [15:0] wram_din; logic wram_en, wram_we;
    logic [7:0]  bram_addr; logic [15:0] bram_din; logic bram_en, bram_we;
    logic        start;
    logic [8:0]  label;
    logic        complete;

    int checks = 0, failures = 0;

    logic [15:0] m_ldm  [640];
    logic [31:0] m_cram [64];
    logic [15:0] m_wram [16384];
    logic [15:0] m_bram [256];
    int          m_label;

    cnn_accel_top dut (
        .CLK(CLK), .RST(RST),
        .AXI_LDM_addra_in(ldm_addr), .AXI_LDM_dina_in(ldm_din),
        .AXI_LDM_ena_in(ldm_en), .AXI_LDM_wea_in(ldm_we),
        .AXI_CRAM_addra_in(cram_addr), .AXI_CRAM_dina_in(cram_din),
        .AXI_CRAM_ena_in(cram_en), .AXI_CRAM_wea_in(cram_we),
        .AXI_WRAM_addra_in(wram_addr), .AXI_WRAM_dina_in(wram_din),
        .AXI_WRAM_ena_in(wram_en), .AXI_WRAM_wea_in(wram_we),
        .AXI_BRAM_addra_in(bram_addr), .AXI_BRAM_dina_in(bram_din),
        .AXI_BRAM_ena_in(bram_en), .AXI_BRAM_wea_in(bram_we),
        .start_in(start), .AXI_LDM_douta_out(label), .complete_out(complete)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctx(input bit last, input bit relu, input bit src, input bit dst,
                                        input int il, input int ol);
        logic [31:0] w;
        w = '0;
        w[31] = last; w[30] = relu; w[29] = src; w[28] = dst;
        w[27:18] = 10'($urandom);
        w[17:9] = il[8:0];
        w[8:0]  = ol[8:0];
        return w;
    endfunction

    function automatic logic [15:0] rnd();
        return 16'($urandom_range(0, 1023)) - 16'd512;
    endfunction

    // All tasks are entered and left on a falling edge.
    task automatic wr_ldm(input int bank, input int idx, input logic [15:0] v, input bit upd);
        logic [4:0] pe;
        logic [3:0] a;
        pe = 5'(idx % 20);
        a  = 4'(idx / 20);
        ldm_addr = {pe, 1'(bank), a}; ldm_din = v; ldm_en = 1'b1; ldm_we = 1'b1;
        @(negedge CLK);
        ldm_en = 1'b0; ldm_we = 1'b0;
        if (upd) m_ldm[bank*BANK + idx] = v;
    endtask

    task automatic wr_c(input int a, input logic [31:0] v);
        cram_addr = 6'(a); cram_din = v; cram_en = 1'b1; cram_we = 1'b1;
        @(negedge CLK);
        cram_en = 1'b0; cram_we = 1'b0;
        m_cram[a] = v;
    endtask

    task automatic wr_w(input int a, input logic [15:0] v);
        wram_addr = 14'(a); wram_din = v; wram_en = 1'b1; wram_we = 1'b1;
        @(negedge CLK);
        wram_en = 1'b0; wram_we = 1'b0;
        m_wram[a] = v;
    endtask

    task automatic wr_b(input int a, input logic [15:0] v);
        bram_addr = 8'(a); bram_din = v; bram_en = 1'b1; bram_we = 1'b1;
        @(negedge CLK);
        bram_en = 1'b0; bram_we = 1'b0;
        m_bram[a] = v;
    endtask

    // Layer model: plain integer arithmetic over the shadow memories.
    task automatic model_run();
        int wp, bp, il, ol, src, dst;
        bit last;
        longint acc, y, best;
        wp = 0; bp = 0; best = 0; m_label = 0;
        for (int c = 0; c < 64; c++) begin
            last = m_cram[c][31] || (c == 63);
            il = int'(m_cram[c][17:9]); ol = int'(m_cram[c][8:0]);
            src = int'(m_cram[c][29]);  dst = int'(m_cram[c][28]);
            for (int o = 0; o < ol; o++) begin
                acc = longint'($signed(m_bram[bp])) * 256;
                for (int i = 0; i < il; i++)
                    acc += longint'($signed(m_ldm[src*BANK + i])) * longint'($signed(m_wram[(wp + i) % 16384]));
                wp = (wp + il) % 16384;
                bp = (bp + 1) % 256;
                y = acc >>> 8;
`ifdef CNN_SAT_EN
                if (y > 32767) y = 32767;
                else if (y < -32768) y = -32768;
`else
                y = longint'($signed(y[15:0]));
`endif
                if (m_cram[c][30] && y < 0) y = 0;
                m_ldm[dst*BANK + o] = y[15:0];
                if (last && (o == 0 || y > best)) begin
                    best = y;
                    m_label = o;
                end
            end
            if (last) break;
        end
    endtask

    task automatic start_pulse(input string tag);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        check({tag, "_drop"}, 32'(complete), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n, mism;
        n = 0;
        while (!complete && n < 20000) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_done"}, 32'(complete), 32'd1);
        check({tag, "_label"}, 32'(label), 32'(m_label));
        mism = 0;
        for (int k = 0; k < 640; k++)
            if (dut.ldm_q[k] !== m_ldm[k]) mism++;
        check({tag, "_ldm_mism"}, 32'(mism), 32'd0);
    endtask

    task automatic run(input string tag);
        model_run();
        start_pulse(tag);
        wait_done(tag);
    endtask

    initial begin
        int il1, ol1, ol2, exp_lbl, saved;
        logic [15:0] exp_ovf;
        ldm_addr = '0; ldm_din = '0; ldm_en = 1'b0; ldm_we = 1'b0;
        cram_addr = '0; cram_din = '0; cram_en = 1'b0; cram_we = 1'b0;
        wram_addr = '0; wram_din = '0; wram_en = 1'b0; wram_we = 1'b0;
        bram_addr = '0; bram_din = '0; bram_en = 1'b0; bram_we = 1'b0;
        start = 1'b0;

        repeat (2) @(negedge CLK);
        check("rst_complete", 32'(complete), 32'd0);
        check("rst_label", 32'(label), 32'd0);
        RST = 1'b1;
        repeat (4) @(negedge CLK);
        check("idle_hold", 32'(complete), 32'd0);
        for (int k = 0; k < 640; k++) wr_ldm(k / BANK, k % BANK, 16'h0000, 1'b1);

        // one layer, identity-ish weights
        wr_ldm(0, 0, 16'h0100, 1'b1); wr_ldm(0, 1, 16'h0200, 1'b1);
        wr_w(0, 16'h0100); wr_w(1, 16'h0000); wr_w(2, 16'h0000);
        wr_w(3, 16'h0100); wr_w(4, 16'h0100); wr_w(5, 16'h0100);
        for (int b = 0; b < 3; b++) wr_b(b, 16'h0000);
        wr_c(0, ctx(1, 0, 0, 1, 2, 3));
        run("one_layer");
        check("one_layer_lbl2", 32'(label), 32'd2);
        check("one_layer_y2", 32'(dut.ldm_q[BANK + 2]), 32'h0300);

        // relu then second layer decided by bias
        wr_w(0, 16'hFF00); wr_w(1, 16'hFF00); wr_w(2, 16'h0100); wr_w(3, 16'h0000);
        for (int k = 4; k < 8; k++) wr_w(k, 16'h0000);
        wr_b(0, 16'h0000); wr_b(1, 16'h0000); wr_b(2, 16'h0100); wr_b(3, 16'h0080);
        wr_c(0, ctx(0, 1, 0, 1, 2, 2));
        wr_c(1, ctx(1, 0, 1, 0, 2, 2));
        run("relu2");
        check("relu2_lbl0", 32'(label), 32'd0);
        check("relu2_zero", 32'(dut.ldm_q[BANK]), 32'h0000);

        // overflow
        for (int i = 0; i < 4; i++) wr_ldm(0, i, 16'h7FFF, 1'b1);
        for (int k = 0; k < 4; k++) wr_w(k, 16'h7FFF);
        for (int k = 4; k < 8; k++) wr_w(k, 16'h0000);
        wr_b(0, 16'h0000); wr_b(1, 16'h0100);
        wr_c(0, ctx(1, 0, 0, 1, 4, 2));
`ifdef CNN_SAT_EN
        exp_ovf = 16'h7FFF; exp_lbl = 0;
`else
        exp_ovf = 16'hFC00; exp_lbl = 1;
`endif
        run("ovf");
        check("ovf_y0", 32'(dut.ldm_q[BANK]), 32'(exp_ovf));
        check("ovf_lbl", 32'(label), 32'(exp_lbl));

        // ties keep lowest index
        wr_ldm(0, 0, 16'h0100, 1'b1);
        for (int k = 0; k < 3; k++) wr_w(k, 16'h0500);
        for (int b = 0; b < 3; b++) wr_b(b, 16'h0000);
        wr_c(0, ctx(1, 0, 0, 1, 1, 3));
        run("tie");
        check("tie_lbl0", 32'(label), 32'd0);

        // skipped layer, then in_len=0 layer yields bias
        wr_b(0, 16'h0040); wr_b(1, 16'h0100);
        wr_c(0, ctx(0, 0, 0, 1, 5, 0));
        wr_c(1, ctx(1, 0, 0, 1, 0, 2));
        run("skip");
        check("skip_lbl1", 32'(label), 32'd1);
        check("skip_bias0", 32'(dut.ldm_q[BANK]), 32'h0040);
        check("skip_bias1", 32'(dut.ldm_q[BANK + 1]), 32'h0100);

        // abort mid-MAC, busy LDM write, ignored start, restart
        for (int i = 0; i < 300; i++) wr_ldm(0, i, rnd(), 1'b1);
        for (int k = 0; k < 1200; k++) wr_w(k, rnd());
        for (int b = 0; b < 4; b++) wr_b(b, rnd());
        wr_c(0, ctx(1, 0, 0, 1, 300, 4));
        start_pulse("abort");
        repeat (100) @(negedge CLK);
        check("abort_busy", 32'(complete), 32'd0);
        RST = 1'b0;
        #1;
        check("abort_complete", 32'(complete), 32'd0);
        check("abort_label", 32'(label), 32'd0);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        check("abort_idle", 32'(complete), 32'd0);
        model_run();
        start_pulse("ctl");
        repeat (50) @(negedge CLK);
        wr_ldm(0, 5, 16'h1234, 1'b0);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        wait_done("ctl");
        saved = m_label;
        run("restart");
        check("restart_same", 32'(label), 32'(saved));

        // random two-layer stacks
        for (int t = 0; t < 6; t++) begin
            il1 = int'($urandom_range(1, 30));
            ol1 = int'($urandom_range(1, 12));
            ol2 = int'($urandom_range(1, 10));
            for (int i = 0; i < il1; i++) wr_ldm(0, i, rnd(), 1'b1);
            for (int k = 0; k < il1*ol1 + ol1*ol2; k++) wr_w(k, rnd());
            for (int b = 0; b < ol1 + ol2; b++) wr_b(b, rnd());
            wr_c(0, ctx(0, 1'($urandom), 0, 1, il1, ol1));
            wr_c(1, ctx(1, 1'($urandom), 1, 0, ol1, ol2));
            run("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
